// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : Instruction fetch FSM with single-cycle decode into registered
//               control strobes. Optional BEQ branch via FETCH_DECODE_BRANCH_EN.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_decode #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [23:0]     imem_data,
    input  logic            stall,
    input  logic            eq_flag,
    output logic            valid,
    output logic            alu_sum,
    output logic            wb,
    output logic            mem_wb,
    output logic            imm_wb,
    output logic            eq_in,
    output logic            lt_in,
    output logic            reset_st,
    output logic            set_st,
    output logic [4:0]      dest,
    output logic [4:0]      source1,
    output logic [4:0]      source2,
    output logic            halted,
    output logic            illegal
);

    localparam logic [3:0] c_OP_NOP   = 4'd0;
    localparam logic [3:0] c_OP_ADD   = 4'd1;
    localparam logic [3:0] c_OP_SUB   = 4'd2;
    localparam logic [3:0] c_OP_LDI   = 4'd3;
    localparam logic [3:0] c_OP_LD    = 4'd4;
    localparam logic [3:0] c_OP_CMPEQ = 4'd5;
    localparam logic [3:0] c_OP_CMPLT = 4'd6;
    localparam logic [3:0] c_OP_SETST = 4'd7;
    localparam logic [3:0] c_OP_CLRST = 4'd8;
    localparam logic [3:0] c_OP_BEQ   = 4'd9;
    localparam logic [3:0] c_OP_JMP   = 4'd10;
    localparam logic [3:0] c_OP_HALT  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_target;
    logic [3:0]      r_op;
    logic            r_req;
    logic            r_valid;
    logic            r_halted;
    logic            r_illegal;
    logic [7:0]      r_strb;
    logic [4:0]      r_dest;
    logic [4:0]      r_src1;
    logic [4:0]      r_src2;

    logic [3:0]      w_op;
    logic [7:0]      w_strb;
    logic            w_bad;
    logic            w_take;
    logic [PC_W-1:0] w_pc_next;

    assign w_op = imem_data[23:20];

    // Strobe vector order: alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st
    always_comb begin
        w_strb = 8'b0000_0000;
        w_bad  = 1'b0;
        case (w_op)
            c_OP_NOP, c_OP_JMP, c_OP_HALT: w_strb = 8'b0000_0000;
            c_OP_ADD:   w_strb = 8'b1100_0000;
            c_OP_SUB:   w_strb = 8'b0100_0000;
            c_OP_LDI:   w_strb = 8'b0101_0000;
            c_OP_LD:    w_strb = 8'b0110_0000;
            c_OP_CMPEQ: w_strb = 8'b0000_1000;
            c_OP_CMPLT: w_strb = 8'b0000_0100;
            c_OP_SETST: w_strb = 8'b0000_0001;
            c_OP_CLRST: w_strb = 8'b0000_0010;
`ifdef FETCH_DECODE_BRANCH_EN
            c_OP_BEQ:   w_strb = 8'b0000_0000;
`endif
            default:    w_bad  = 1'b1;
        endcase
    end

`ifdef FETCH_DECODE_BRANCH_EN
    assign w_take = (r_op == c_OP_BEQ) && eq_flag;
`else
    logic w_unused_eq;
    assign w_unused_eq = eq_flag;
    assign w_take      = 1'b0;
`endif

    assign w_pc_next = ((r_op == c_OP_JMP) || w_take) ? r_target : r_pc + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_target  <= '0;
            r_op      <= c_OP_NOP;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_strb    <= '0;
            r_dest    <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state  <= S_ISSUE;
                        r_req    <= 1'b0;
                        r_valid  <= 1'b1;
                        r_strb   <= w_strb;
                        r_dest   <= imem_data[19:15];
                        r_src1   <= imem_data[14:10];
                        r_src2   <= imem_data[9:5];
                        r_op     <= w_op;
                        r_target <= imem_data[PC_W-1:0];
                        if (w_bad) begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Everything holds while the processor stalls.
                    if (!stall) begin
                        r_valid <= 1'b0;
                        r_strb  <= '0;
                        r_pc    <= w_pc_next;
                        if (r_op == c_OP_HALT) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign valid     = r_valid;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign {alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st} = r_strb;
    assign dest      = r_dest;
    assign source1   = r_src1;
    assign source2   = r_src2;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Directed scoreboard bench for fetch_decode (PC_W = 8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_decode;

`ifdef FETCH_DECODE_BRANCH_EN
    localparam bit c_BRANCH = 1'b1;
`else
    localparam bit c_BRANCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [23:0] imem_data;
    logic        stall;
    logic        eq_flag;
    logic        valid;
    logic        alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st;
    logic [4:0]  dest, source1, source2;
    logic        halted;
    logic        illegal;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [22:0] sb[$];
    logic [7:0]  m_pc;
    logic        m_illegal;

    fetch_decode #(.PC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .stall     (stall),
        .eq_flag   (eq_flag),
        .valid     (valid),
        .alu_sum   (alu_sum),
        .wb        (wb),
        .mem_wb    (mem_wb),
        .imm_wb    (imm_wb),
        .eq_in     (eq_in),
        .lt_in     (lt_in),
        .reset_st  (reset_st),
        .set_st    (set_st),
        .dest      (dest),
        .source1   (source1),
        .source2   (source2),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [22:0] obs_bundle();
        return {alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st,
                dest, source1, source2};
    endfunction

    // Reference decode: {alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st}
    function automatic logic [22:0] exp_bundle(input logic [23:0] ins);
        logic [7:0] s;
        case (ins[23:20])
            4'd1:    s = 8'b1100_0000;
            4'd2:    s = 8'b0100_0000;
            4'd3:    s = 8'b0101_0000;
            4'd4:    s = 8'b0110_0000;
            4'd5:    s = 8'b0000_1000;
            4'd6:    s = 8'b0000_0100;
            4'd7:    s = 8'b0000_0001;
            4'd8:    s = 8'b0000_0010;
            default: s = 8'b0000_0000;
        endcase
        return {s, ins[19:15], ins[14:10], ins[9:5]};
    endfunction

    function automatic logic is_illegal(input logic [23:0] ins);
        return (ins[23:20] inside {4'd11, 4'd12, 4'd13, 4'd14}) ||
               (ins[23:20] == 4'd9 && !c_BRANCH);
    endfunction

    function automatic logic [23:0] mk(input logic [3:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 5'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Handshake one instruction, check its bundle for 'hold' cycles, then the next fetch/halt.
    task automatic do_fetch(input logic [7:0] addr, input logic [23:0] ins,
                            input int hold, input logic eq);
        int          n;
        logic [22:0] e;
        logic [3:0]  op;
        n  = 0;
        op = ins[23:20];
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req, 1);
        check("fetch_addr", imem_addr, addr);
        check("valid_in_fetch", valid, 0);
        imem_ack  = 1'b1;
        imem_data = ins;
        stall     = (hold > 1);
        eq_flag   = eq;
        sb.push_back(exp_bundle(ins));
        if (is_illegal(ins)) m_illegal = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 24'($urandom);
        e = sb.pop_front();
        check("valid", valid, 1);
        check("bundle", obs_bundle(), e);
        check("req_in_issue", imem_req, 0);
        check("illegal", illegal, m_illegal);
        for (int i = 1; i < hold; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            check("hold_valid", valid, 1);
            check("hold_bundle", obs_bundle(), e);
            check("hold_req", imem_req, 0);
            check("hold_addr", imem_addr, addr);
            if (i == hold - 1) begin
                stall    = 1'b0;
                imem_ack = 1'b0;
            end
        end
        if (op == 4'd10 || (op == 4'd9 && c_BRANCH && eq)) m_pc = ins[7:0];
        else m_pc = m_pc + 8'd1;
        @(negedge clk);
        eq_flag = 1'b0;
        check("valid_after", valid, 0);
        if (op == 4'd15) begin
            check("halted", halted, 1);
            check("req_after_halt", imem_req, 0);
        end else begin
            check("next_req", imem_req, 1);
            check("next_addr", imem_addr, m_pc);
            check("not_halted", halted, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        stall     = 1'b0;
        eq_flag   = 1'b0;
        m_pc      = 8'd0;
        m_illegal = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", valid, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_bundle", obs_bundle(), 0);
        rst_n = 1'b1;

        do_fetch(m_pc, mk(4'd1, 5'd3, 5'd1, 5'd2), 1, 1'b0);      // ADD
        do_fetch(m_pc, mk(4'd3, 5'd7, 5'd4, 5'd9), 3, 1'b0);      // LDI, stalled
        do_fetch(m_pc, mk(4'd2, 5'd4, 5'd5, 5'd6), 1, 1'b0);      // SUB
        do_fetch(m_pc, mk(4'd4, 5'd8, 5'd9, 5'd10), 2, 1'b0);     // LD
        do_fetch(m_pc, mk(4'd5, 5'd0, 5'd11, 5'd12), 1, 1'b0);    // CMPEQ
        do_fetch(m_pc, mk(4'd6, 5'd0, 5'd13, 5'd14), 1, 1'b0);    // CMPLT
        do_fetch(m_pc, mk(4'd7, 5'd31, 5'd30, 5'd29), 1, 1'b0);   // SETST
        do_fetch(m_pc, mk(4'd8, 5'd1, 5'd1, 5'd1), 1, 1'b0);      // CLRST
        do_fetch(m_pc, mk(4'd0, 5'd1, 5'd2, 5'd3), 1, 1'b0);      // NOP
        do_fetch(m_pc, {4'd10, 5'd17, 5'd18, 2'b00, 8'hFE}, 1, 1'b0); // JMP 0xFE
        do_fetch(m_pc, mk(4'd0, 5'd0, 5'd0, 5'd0), 1, 1'b0);      // NOP @ FE
        do_fetch(m_pc, mk(4'd0, 5'd0, 5'd0, 5'd0), 1, 1'b0);      // NOP @ FF -> 00
        check("wrap_pc", m_pc, 8'h00);
        do_fetch(m_pc, {4'd9, 5'd1, 5'd2, 2'b00, 8'h20}, 1, 1'b1); // BEQ taken
        do_fetch(m_pc, {4'd9, 5'd1, 5'd2, 2'b00, 8'h20}, 1, 1'b0); // BEQ not taken
        check("beq_illegal", illegal, !c_BRANCH);

        // Asynchronous reset in the middle of a fetch cycle.
        check("pre_rst_req", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", imem_req, 0);
        check("async_addr", imem_addr, 0);
        check("async_illegal", illegal, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        m_pc      = 8'd0;
        m_illegal = 1'b0;

        do_fetch(m_pc, mk(4'd12, 5'd5, 5'd6, 5'd7), 1, 1'b0);     // illegal opcode
        do_fetch(m_pc, mk(4'd15, 5'd0, 5'd0, 5'd0), 1, 1'b0);     // HALT
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_req", imem_req, 0);
            check("halt_valid", valid, 0);
            check("halt_flag", halted, 1);
            check("halt_illegal", illegal, 1);
        end
        imem_ack = 1'b0;
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter: PC_W, default 8, program-counter and instruction-address width.
REQ-002 Ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (current PC)
- imem_ack  in  1  instruction word present on imem_data this cycle
- imem_data  in  24  instruction word
- stall  in  1  downstream processor cannot accept a new control bundle
- eq_flag  in  1  equality status from the processor
- valid  out  1  control bundle below is live
- alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st  out  1 each  processor control strobes
- dest, source1, source2  out  5 each  register specifiers
- halted  out  1  HALT executed
- illegal  out  1  sticky illegal-opcode flag
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low.

Function
REQ-004 Instruction fields: op = [23:20], dest = [19:15], source1 = [14:10], source2 = [9:5], jump target = [PC_W-1:0].
REQ-005 FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH -> ISSUE when imem_ack is high.
- ISSUE -> FETCH when stall is low.
- ISSUE -> HALT when stall is low and the opcode is HALT.
- HALT is terminal until reset.
REQ-006 imem_req is high in FETCH only; imem_ack outside FETCH is ignored.
REQ-007 Instruction latency: the word is captured on the imem_ack edge; valid and the decoded bundle appear the following cycle and are registered outputs.
REQ-008 Decode table (unlisted strobes 0):
- 0 NOP: no strobes
- 1 ADD: alu_sum=1, wb=1
- 2 SUB: wb=1
- 3 LDI: imm_wb=1, wb=1
- 4 LD: mem_wb=1, wb=1
- 5 CMPEQ: eq_in=1
- 6 CMPLT: lt_in=1
- 7 SETST: set_st=1
- 8 CLRST: reset_st=1
- 10 JMP: no strobes
- 15 HALT: no strobes
REQ-009 Any other opcode decodes as NOP and sets illegal, which stays high until reset.
REQ-010 While valid=1 and stall=1, every output holds stable, PC holds, and no fetch is issued.
REQ-011 PC increments by 1 when ISSUE completes (stall low) and wraps from 2^PC_W-1 to 0.
REQ-012 A JMP loads PC with its target instead of incrementing.
REQ-013 valid is low in IDLE, FETCH and HALT; halted is high only in HALT.
REQ-014 Specifier outputs carry the instruction fields for every opcode; they are don't-care to the processor when the corresponding strobe is low.

Reset
REQ-015 On rst_n low, the following take effect immediately, independent of clk:
- state = IDLE, PC = 0
- imem_req, valid, halted and illegal = 0
- all strobes and specifiers = 0
REQ-016 Reset asserted mid-fetch drops imem_req at once; after release, fetch restarts at address 0.

Configuration
REQ-017 Macro FETCH_DECODE_BRANCH_EN:
- Defined: opcode 9 (BEQ) loads PC with its target when eq_flag is high at the issuing edge; otherwise PC increments. BEQ asserts no strobes.
- Undefined: opcode 9 is illegal per REQ-009, and eq_flag is ignored.

Verification
REQ-018 Reset, then ADD with dest=3, source1=1, source2=2 acked at address 0 -> one cycle later: valid=1, alu_sum=1, wb=1, dest=3, source1=1, source2=2; the next fetch uses imem_addr=1.
REQ-019 LDI issued with stall high for 3 cycles -> imm_wb=1 and dest held for 3 cycles; imem_req low throughout; fetch resumes the cycle after stall falls.
REQ-020 JMP with target 0xFE, then NOP, NOP -> fetches at 0xFE, 0xFF, 0x00 (wrap-around).
REQ-021 Opcode 12, then HALT -> illegal=1 and stays 1; halted=1; imem_req stays 0 afterwards.
REQ-022 rst_n pulsed low during FETCH with imem_req=1 -> imem_req falls without a clock edge; after release, the first fetch is at address 0 and illegal=0.
REQ-023 With FETCH_DECODE_BRANCH_EN defined, BEQ with target 0x20: eq_flag=1 -> next fetch at 0x20; eq_flag=0 -> next fetch at PC+1. Without the macro, the same BEQ sets illegal=1.
